ysyx_22050243_cache_axi_arbiter: RTL and testbench
==================================================

YSYX_22050243_CACHE_AXI_ARBITER -- requirements
Module: ysyx_22050243_cache_axi_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 128, giving the cache line width in bits; all data ports are LINE_W wide.
REQ-002 The block SHALL have one clock, clk, and a synchronous active-high reset, rst:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-003 The icache port SHALL be read-only:
- ic_req_addr  input  64  icache refill address.
- ic_req_valid  input  1  icache request; held high until the icache sees ic_res_valid.
- ic_res_valid  output  1  one-cycle pulse: the line is available on ic_rdata.
- ic_rdata  output  LINE_W  refill line data.
REQ-004 The dcache port SHALL support read and write:
- dc_req_addr  input  64  dcache request address.
- dc_req_valid  input  1  dcache request; held until dc_res_valid.
- dc_req_wen  input  1  1 = line writeback, 0 = refill.
- dc_wdata  input  LINE_W  writeback line.
- dc_res_valid  output  1  one-cycle pulse: read data is valid, or the write has completed.
- dc_rdata  output  LINE_W  refill data.
REQ-005 The memory-side port SHALL be:
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  line-aligned address.
- mem_req_wen  output  1  write request.
- mem_wdata  output  LINE_W  write data.
- mem_res_valid  input  1  response pulse from memory.
- mem_rdata  input  LINE_W  response data.

Function
REQ-006 The block SHALL use a state machine with states IDLE, REQ, WAIT, RESP and COOL.
REQ-007 In IDLE, the block SHALL grant according to which requests are asserted:
- one valid request: grant it.
- both valid: grant the port not granted last (round-robin pointer last_gnt).
- In each case, latch the owner, the address, wen (forced 0 for icache) and wdata, then go to REQ.
REQ-008 The latched address SHALL be {addr[31:4], 4'b0}; bits 63:32 SHALL be ignored.
REQ-009 In REQ, mem_req_valid SHALL be 1 and the latched fields SHALL drive mem_req_*.
- mem_req_ready=1 moves to WAIT; the fields SHALL stay stable until then.
- mem_req_ready and mem_res_valid in the same cycle moves directly to RESP, capturing data.
REQ-010 In WAIT, mem_req_valid SHALL be 0; on mem_res_valid, mem_rdata SHALL be captured into a line register and the state SHALL go to RESP.
- mem_res_valid arriving in IDLE, COOL or REQ-without-ready SHALL be ignored.
REQ-011 In RESP, exactly the owner's res_valid SHALL be 1 for one cycle, with the captured line on the owner's rdata.
- The other port's res_valid SHALL be 0.
- last_gnt SHALL update to the owner; the next state SHALL be COOL.
REQ-012 COOL SHALL last one cycle with requests ignored, so that a request still held high in the response cycle is not re-granted; the next state SHALL be IDLE.
REQ-013 ic_rdata and dc_rdata SHALL both be driven from the line register; data outside the owner's RESP cycle carries no meaning.
REQ-014 Request latency SHALL be fixed:
- from request asserted in IDLE with immediate ready to the memory request: 1 cycle (IDLE->REQ).
- from mem_res_valid to the owner's res_valid: exactly 1 cycle.
REQ-015 A requester dropping valid after it has been granted SHALL NOT abort the transaction; the response SHALL still be pulsed.
REQ-016 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-017 While rst=1, the state SHALL be IDLE, last_gnt SHALL be icache (so dcache wins the first tie), and all outputs SHALL be 0, including the line register.
REQ-018 Reset asserted mid-transaction SHALL abandon it:
- no res_valid pulse SHALL follow.
- a late mem_res_valid after reset SHALL be ignored per REQ-010.

Verification
REQ-019 Icache only: ic_req_addr=0x8000_0123, ready=1, memory responds 2 cycles after accept with 0xA5..A5 -> mem_req_addr=0x8000_0120, mem_req_wen=0, ic_res_valid for one cycle with ic_rdata=0xA5..A5, dc_res_valid=0.
REQ-020 Simultaneous requests after reset -> dcache granted first, icache second, a COOL cycle between the two transactions, no double grant of the dcache request.
REQ-021 Dcache writeback: addr=0x8000_1008, wen=1, wdata=0x1234, ready held 0 for 3 cycles -> mem_req_valid and its fields stay stable for 4 cycles; dc_res_valid pulses one cycle after mem_res_valid.
REQ-022 Requester drops valid during WAIT -> the response pulse is still issued once; the state returns to IDLE via COOL.
REQ-023 rst pulsed during WAIT, followed by a stray mem_res_valid -> all outputs are 0 and no res_valid pulse occurs; the next icache request completes normally.

Source files
------------

// File: rtl/ysyx_22050243_cache_axi_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache and dcache.
// One transaction in flight; a COOL cycle after each response keeps a still-held request from being re-granted.
module ysyx_22050243_cache_axi_arbiter #(
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       ic_req_addr,
  input  logic              ic_req_valid,
  output logic              ic_res_valid,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic [63:0]       dc_req_addr,
  input  logic              dc_req_valid,
  input  logic              dc_req_wen,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_res_valid,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  output logic              mem_req_wen,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_res_valid,
  input  logic [LINE_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_COOL} state_t;

  localparam logic OWN_IC = 1'b0;

  state_t              r_state;
  logic                r_owner;
  logic                r_last_gnt;
  logic                r_mem_req_valid;
  logic                r_mem_req_wen;
  logic                r_ic_res_valid;
  logic                r_dc_res_valid;
  logic [31:0]         r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_line;

  logic                w_grant_dc;
  logic [63:0]         w_grant_addr;
  logic                w_unused;

  // dcache wins when alone, or on a tie when the icache was served last
  assign w_grant_dc   = dc_req_valid && (!ic_req_valid || (r_last_gnt == OWN_IC));
  assign w_grant_addr = w_grant_dc ? dc_req_addr : ic_req_addr;
  assign w_unused     = ^{w_grant_addr[63:32], w_grant_addr[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_owner         <= OWN_IC;
      r_last_gnt      <= OWN_IC;
      r_mem_req_valid <= 1'b0;
      r_mem_req_wen   <= 1'b0;
      r_ic_res_valid  <= 1'b0;
      r_dc_res_valid  <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_line          <= '0;
    end else begin
      r_ic_res_valid <= 1'b0;
      r_dc_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            r_owner         <= w_grant_dc;
            r_addr          <= {w_grant_addr[31:4], 4'b0000};
            r_mem_req_wen   <= w_grant_dc && dc_req_wen;
            r_wdata         <= w_grant_dc ? dc_wdata : '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            if (mem_res_valid) begin
              r_line         <= mem_rdata;
              r_ic_res_valid <= (r_owner == OWN_IC);
              r_dc_res_valid <= (r_owner != OWN_IC);
              r_state        <= S_RESP;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_res_valid) begin
            r_line         <= mem_rdata;
            r_ic_res_valid <= (r_owner == OWN_IC);
            r_dc_res_valid <= (r_owner != OWN_IC);
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          r_last_gnt <= r_owner;
          r_state    <= S_COOL;
        end
        S_COOL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_mem_req_wen;
  assign mem_wdata     = r_wdata;
  assign ic_res_valid  = r_ic_res_valid;
  assign dc_res_valid  = r_dc_res_valid;
  assign ic_rdata      = r_line;
  assign dc_rdata      = r_line;
endmodule

// File: tb/tb_ysyx_22050243_cache_axi_arbiter.sv
// Bench for the icache/dcache memory arbiter: vector table plus scoreboard-driven memory responder.
module tb_ysyx_22050243_cache_axi_arbiter;
  localparam int LW = 128;

  logic          clk;
  logic          rst;
  logic [63:0]   ic_req_addr;
  logic          ic_req_valid;
  logic          ic_res_valid;
  logic [LW-1:0] ic_rdata;
  logic [63:0]   dc_req_addr;
  logic          dc_req_valid;
  logic          dc_req_wen;
  logic [LW-1:0] dc_wdata;
  logic          dc_res_valid;
  logic [LW-1:0] dc_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_req_wen;
  logic [LW-1:0] mem_wdata;
  logic          mem_res_valid;
  logic [LW-1:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int ic_pulses = 0;
  int dc_pulses = 0;
  int exp_ic = 0;
  int exp_dc = 0;

  typedef struct {
    logic          dc;
    logic [31:0]   addr;
    logic          wen;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } sb_t;

  typedef struct {
    logic          ic_v;
    logic [63:0]   ic_a;
    logic [31:0]   ic_exp;
    logic [LW-1:0] ic_rd;
    logic          dc_v;
    logic [63:0]   dc_a;
    logic [31:0]   dc_exp;
    logic          dc_w;
    logic [LW-1:0] dc_wd;
    logic [LW-1:0] dc_rd;
    int            rdy;
    int            rsp;
    logic          dc_first;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];

  ysyx_22050243_cache_axi_arbiter #(.LINE_W(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ic_req_addr   (ic_req_addr),
    .ic_req_valid  (ic_req_valid),
    .ic_res_valid  (ic_res_valid),
    .ic_rdata      (ic_rdata),
    .dc_req_addr   (dc_req_addr),
    .dc_req_valid  (dc_req_valid),
    .dc_req_wen    (dc_req_wen),
    .dc_wdata      (dc_wdata),
    .dc_res_valid  (dc_res_valid),
    .dc_rdata      (dc_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_wdata     (mem_wdata),
    .mem_res_valid (mem_res_valid),
    .mem_rdata     (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent pulse counter, compared against the scoreboard totals at the end
  always @(negedge clk) begin
    if (!rst) begin
      if (ic_res_valid) ic_pulses <= ic_pulses + 1;
      if (dc_res_valid) dc_pulses <= dc_pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, LW'(mem_req_valid), LW'(1'b0));
    chk({tag, "_mem_req_addr"},  LW'(mem_req_addr),  LW'(32'h0));
    chk({tag, "_mem_req_wen"},   LW'(mem_req_wen),   LW'(1'b0));
    chk({tag, "_mem_wdata"},     mem_wdata,          '0);
    chk({tag, "_ic_res_valid"},  LW'(ic_res_valid),  LW'(1'b0));
    chk({tag, "_dc_res_valid"},  LW'(dc_res_valid),  LW'(1'b0));
    chk({tag, "_ic_rdata"},      ic_rdata,           '0);
    chk({tag, "_dc_rdata"},      dc_rdata,           '0);
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("quiet_mem_req_valid", LW'(mem_req_valid), LW'(1'b0));
      chk("quiet_res_valid", LW'(ic_res_valid | dc_res_valid), LW'(1'b0));
    end
  endtask

  function automatic vec_t mkvec(
    input logic ic_v, input logic [63:0] ic_a, input logic [31:0] ic_exp, input logic [LW-1:0] ic_rd,
    input logic dc_v, input logic [63:0] dc_a, input logic [31:0] dc_exp, input logic dc_w,
    input logic [LW-1:0] dc_wd, input logic [LW-1:0] dc_rd, input int rdy, input int rsp,
    input logic dc_first);
    vec_t v;
    v.ic_v = ic_v; v.ic_a = ic_a; v.ic_exp = ic_exp; v.ic_rd = ic_rd;
    v.dc_v = dc_v; v.dc_a = dc_a; v.dc_exp = dc_exp; v.dc_w = dc_w;
    v.dc_wd = dc_wd; v.dc_rd = dc_rd; v.rdy = rdy; v.rsp = rsp; v.dc_first = dc_first;
    return v;
  endfunction

  // Acts as memory for the transaction at the scoreboard head and checks the response
  task automatic serve(input int rdy_dly, input int rsp_dly, input bit first, input bit drop_wait);
    sb_t e;
    int  n;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL serve_sb: got empty scoreboard expected an entry");
      return;
    end
    e = sb[0];
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("mem_req_valid", LW'(mem_req_valid), LW'(1'b1));
    if (first) chk("grant_latency", LW'(n), LW'(1));
    chk("mem_req_addr", LW'(mem_req_addr), LW'(e.addr));
    chk("mem_req_wen", LW'(mem_req_wen), LW'(e.wen));
    if (e.wen) chk("mem_wdata", mem_wdata, e.wdata);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("stall_valid", LW'(mem_req_valid), LW'(1'b1));
      chk("stall_addr", LW'(mem_req_addr), LW'(e.addr));
      chk("stall_wen", LW'(mem_req_wen), LW'(e.wen));
      if (e.wen) chk("stall_wdata", mem_wdata, e.wdata);
    end
    mem_req_ready = 1'b1;
    if (rsp_dly == 0) begin
      mem_res_valid = 1'b1;
      mem_rdata     = e.rdata;
    end
    tick();
    mem_req_ready = 1'b0;
    mem_res_valid = 1'b0;
    mem_rdata     = ~e.rdata;
    if (rsp_dly > 0) begin
      chk("wait_req_low", LW'(mem_req_valid), LW'(1'b0));
      if (drop_wait) begin
        if (e.dc) dc_req_valid = 1'b0;
        else      ic_req_valid = 1'b0;
      end
      for (int i = 1; i < rsp_dly; i++) begin
        tick();
        chk("wait_no_resp", LW'(ic_res_valid | dc_res_valid), LW'(1'b0));
      end
      mem_res_valid = 1'b1;
      mem_rdata     = e.rdata;
      tick();
      mem_res_valid = 1'b0;
      mem_rdata     = ~e.rdata;
    end
    e = sb.pop_front();
    chk("ic_res_valid", LW'(ic_res_valid), LW'(!e.dc));
    chk("dc_res_valid", LW'(dc_res_valid), LW'(e.dc));
    if (!e.wen) begin
      if (e.dc) chk("dc_rdata", dc_rdata, e.rdata);
      else      chk("ic_rdata", ic_rdata, e.rdata);
    end
    if (e.dc) exp_dc++;
    else      exp_ic++;
    $display("txn %s addr=%08h wen=%0d rdata=%0h", e.dc ? "dcache" : "icache", e.addr, e.wen, e.rdata);
    tick();
    chk("pulse_width", LW'(ic_res_valid | dc_res_valid), LW'(1'b0));
    if (e.dc) dc_req_valid = 1'b0;
    else      ic_req_valid = 1'b0;
  endtask

  task automatic push(input logic dc, input logic [31:0] addr, input logic wen,
                      input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    sb_t e;
    e.dc = dc; e.addr = addr; e.wen = wen; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  initial begin
    vec_t v;
    int   n;
    rst = 1'b1;
    ic_req_addr = '0; ic_req_valid = 1'b0;
    dc_req_addr = '0; dc_req_valid = 1'b0; dc_req_wen = 1'b0; dc_wdata = '0;
    mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_rdata = '0;

    vecs[0] = mkvec(1, 64'h0000_0000_8000_0123, 32'h8000_0120, {4{32'hA5A5_A5A5}},
                    0, 64'h0, 32'h0, 0, '0, '0, 0, 2, 0);
    vecs[1] = mkvec(1, 64'h0000_0000_8000_0044, 32'h8000_0040, {4{32'h1111_2222}},
                    1, 64'h0000_0000_8000_2004, 32'h8000_2000, 0, '0, {4{32'h3C3C_0F0F}}, 1, 1, 1);
    vecs[2] = mkvec(0, 64'h0, 32'h0, '0,
                    1, 64'h0000_0000_8000_1008, 32'h8000_1000, 1, 128'h1234, 128'hDEAD, 3, 1, 1);
    vecs[3] = mkvec(1, 64'hFFFF_FFFF_1234_567F, 32'h1234_5670, {2{64'h0123_4567_89AB_CDEF}},
                    1, 64'h0000_0001_0000_0010, 32'h0000_0010, 1, {4{32'hCAFE_F00D}}, 128'h0, 1, 0, 0);
    vecs[4] = mkvec(1, 64'h0000_0000_8000_0FF0, 32'h8000_0FF0, {4{32'h5555_AAAA}},
                    1, 64'hDEAD_BEEF_8000_000C, 32'h8000_0000, 0, '0, {4{32'h0BAD_F00D}}, 2, 3, 0);
    vecs[5] = mkvec(0, 64'h0, 32'h0, '0,
                    1, 64'h0000_0000_8000_3FFF, 32'h8000_3FF0, 0, '0, {4{32'h7777_8888}}, 0, 0, 1);
    vecs[6] = mkvec(1, 64'h0000_0000_8000_0000, 32'h8000_0000, {4{32'hFFFF_FFFF}},
                    1, 64'h0000_0000_8000_0010, 32'h8000_0010, 0, '0, {4{32'h00FF_00FF}}, 0, 1, 0);

    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      if (v.ic_v) begin
        ic_req_addr  = v.ic_a;
        ic_req_valid = 1'b1;
      end
      if (v.dc_v) begin
        dc_req_addr  = v.dc_a;
        dc_req_wen   = v.dc_w;
        dc_wdata     = v.dc_wd;
        dc_req_valid = 1'b1;
      end
      if (v.dc_first && v.dc_v) push(1'b1, v.dc_exp, v.dc_w, v.dc_wd, v.dc_rd);
      if (v.ic_v) push(1'b0, v.ic_exp, 1'b0, '0, v.ic_rd);
      if (!v.dc_first && v.dc_v) push(1'b1, v.dc_exp, v.dc_w, v.dc_wd, v.dc_rd);
      n = (v.ic_v ? 1 : 0) + (v.dc_v ? 1 : 0);
      for (int j = 0; j < n; j++) serve(v.rdy, v.rsp, j == 0, 1'b0);
      quiet(3);
    end

    // Requester withdraws while waiting on memory: response still arrives once
    ic_req_addr  = 64'h0000_0000_8000_0200;
    ic_req_valid = 1'b1;
    push(1'b0, 32'h8000_0200, 1'b0, '0, {4{32'h2222_0022}});
    serve(0, 2, 1'b1, 1'b1);
    quiet(3);

    // Reset during WAIT abandons the transaction; a stray response is ignored
    ic_req_addr  = 64'h0000_0000_8000_0300;
    ic_req_valid = 1'b1;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("rst_seq_req", LW'(mem_req_valid), LW'(1'b1));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rst_seq_wait", LW'(mem_req_valid), LW'(1'b0));
    rst = 1'b1;
    ic_req_valid = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    mem_res_valid = 1'b1;
    mem_rdata = '1;
    tick();
    mem_res_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stray_res_valid", LW'(ic_res_valid | dc_res_valid), LW'(1'b0));
      chk("stray_ic_rdata", ic_rdata, '0);
      chk("stray_mem_req_valid", LW'(mem_req_valid), LW'(1'b0));
      tick();
    end

    ic_req_addr  = 64'h0000_0000_8000_0404;
    ic_req_valid = 1'b1;
    push(1'b0, 32'h8000_0400, 1'b0, '0, {4{32'h4040_0404}});
    serve(1, 1, 1'b1, 1'b0);
    quiet(3);

    chk("ic_pulse_count", LW'(ic_pulses), LW'(exp_ic));
    chk("dc_pulse_count", LW'(dc_pulses), LW'(exp_dc));
    chk("scoreboard_empty", LW'(sb.size()), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
